point_ram_arbiter: RTL and testbench
====================================

// Module: point_ram_arbiter
// PURPOSE
//  Shares the single-port point RAM (CSB/WEB/OEB, active-low) between two requesters:
//  - host loader: writes or reads points;
//  - k-means controller: reads points during the classification passes.
//  Registered RAM command stage, per-requester read-data-valid return, and a core lock
//  with a host anti-starvation override.
// PARAMETERS
//  ADDR_WIDTH      9    RAM address width
//  DATA_WIDTH      50   RAM word width
//  MAX_WAIT        15   host wait cycles before a forced host grant (1..2^WAIT_CNT_WIDTH-1)
//  WAIT_CNT_WIDTH  4    width of the host wait counter
// PORTS
//  clk         in   1           clock
//  rst         in   1           reset; asynchronous, active-high
//  host_req    in   1           host access request, level; held until host_gnt
//  host_we     in   1           1 = write, 0 = read
//  host_addr   in   ADDR_WIDTH  host address
//  host_wdata  in   DATA_WIDTH  host write data
//  host_gnt    out  1           host access accepted this cycle (combinational)
//  host_rvalid out  1           ram_rdata is a host read result
//  core_req    in   1           controller read request, level
//  core_lock   in   1           classification pass active; core has priority
//  core_addr   in   ADDR_WIDTH  controller read address
//  core_gnt    out  1           core access accepted this cycle (combinational)
//  core_rvalid out  1           ram_rdata is a core read result
//  ram_addr    out  ADDR_WIDTH  RAM A
//  ram_wdata   out  DATA_WIDTH  RAM D
//  ram_csb_n   out  1           RAM chip select, active-low
//  ram_web_n   out  1           RAM write enable, active-low
//  ram_oeb_n   out  1           RAM output enable, active-low
// BEHAVIOUR
//  Reset values: ram_csb_n=1, ram_web_n=1, ram_oeb_n=1, ram_addr=0, ram_wdata=0,
//   host_rvalid=0, core_rvalid=0, wait_cnt=0, state=IDLE, last_winner=CORE.
//   host_gnt and core_gnt are 0 while rst is high.
//  FSM states:
//   - IDLE: no RAM command this cycle.
//   - HOST: RAM pins carry a host command.
//   - CORE: RAM pins carry a core command.
//   The next state equals the arbitration winner of the current cycle; IDLE if none.
//  Arbitration (combinational, cycle N), priority order:
//   1 host_req && wait_cnt==MAX_WAIT       -> host wins (forced)
//   2 core_req && core_lock                -> core wins
//   3 host_req && core_req, no lock        -> round-robin: winner != last_winner
//   4 single requester                     -> that requester wins
//   At most one grant per cycle. last_winner updates on every grant.
//  Command timing:
//   - Winner's addr/wdata/we are registered at the end of cycle N and drive the RAM
//     pins in N+1.
//   - Write: csb_n=0, web_n=0, oeb_n=1. Read: csb_n=0, web_n=1, oeb_n=0.
//   - IDLE: csb_n=1, web_n=1, oeb_n=1; addr and wdata hold their last values.
//   - Back-to-back grants produce back-to-back commands; no turnaround cycle.
//  Read latency:
//   - RAM data is valid one cycle after the command, so *_rvalid pulses in N+2
//     for a read granted in N.
//   - Host writes produce no rvalid.
//   - rvalid is a 2-deep shift of {who, is_read}; at most one rvalid is high per cycle.
//  Requester rule: a requester presents its next access in the cycle after gnt; the
//   arbiter never re-samples a granted request.
//  wait_cnt:
//   - +1 each cycle with host_req && !host_gnt, saturating at MAX_WAIT.
//   - Cleared on host_gnt or when host_req is low.
//  Boundaries:
//   - core_lock with no core_req: host is served normally.
//   - core_lock drop mid-stream: takes effect the same cycle; round-robin resumes.
//   - Forced host grant: the core stalls exactly one cycle (core_gnt=0), and the core
//     request is served next cycle if it is still locked.
//   - Request deasserted before grant: no access is made and no error is flagged.
//   - Reset mid-operation: the in-flight command is aborted; pins return to idle and
//     pending rvalids are dropped.
// TESTING
//  1 Host only: write 0x1A5 @addr 3, then read @3 -> write command next cycle
//    (web_n=0); host_rvalid 2 cycles after the read grant, with ram_rdata=0x1A5.
//  2 Core lock stream: core reads addrs 0..7 back-to-back under lock, host idle ->
//    8 consecutive core_gnt; core_rvalid high for 8 cycles starting 2 cycles after
//    the first grant.
//  3 Starvation: lock held, core requests continuously, host requests from cycle 0,
//    MAX_WAIT=15 -> host_gnt at cycle 15, core_gnt low in that cycle only,
//    wait_cnt back to 0.
//  4 No lock, both requesting continuously -> grants alternate starting with host
//    (last_winner=CORE after reset).
//  5 Assert rst during a pending core read (between command and rvalid) ->
//    core_rvalid never pulses; csb_n=1 asynchronously.
//  6 Host req pulsed for 1 cycle while lost to a locked core -> no host command;
//    wait_cnt returns to 0.

Source files
------------

// File: rtl/point_ram_arbiter.sv
// Point RAM arbiter: shares one single-port point RAM between the host loader
// (reads and writes) and the k-means controller (reads only).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   host_req/we/addr/wdata    host access request (level, held until host_gnt)
//   host_gnt, host_rvalid     host grant (combinational), host read data valid
//   core_req/lock/addr        controller read request, classification-pass priority
//   core_gnt, core_rvalid     core grant (combinational), core read data valid
//   ram_addr/wdata            registered RAM address and write data
//   ram_csb_n/web_n/oeb_n     active-low RAM chip select, write enable, output enable
//
// A grant in cycle N registers the command so it drives the RAM pins in N+1.
// Read data comes back in N+2, tagged with its owner by a two-stage shift.
module point_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned DATA_WIDTH     = 50,
  parameter int unsigned MAX_WAIT       = 15,
  parameter int unsigned WAIT_CNT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  input  logic                  core_req,
  input  logic                  core_lock,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_csb_n,
  output logic                  ram_web_n,
  output logic                  ram_oeb_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOST = 2'd1;
  localparam logic [1:0] CORE = 2'd2;

  localparam logic WIN_HOST = 1'b0;
  localparam logic WIN_CORE = 1'b1;

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LIMIT = WAIT_CNT_WIDTH'(MAX_WAIT);

  logic [1:0]                state, state_next;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt, wait_cnt_next;
  logic                      last_winner;
  logic                      cmd_we;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [1:0]                rd_valid;  // [0]: command stage, [1]: data-return stage
  logic [1:0]                rd_host;
  logic                      host_win, core_win;

  // Arbitration, highest priority first. No grants while in reset.
  always_comb begin
    host_win = 1'b0;
    core_win = 1'b0;
    if (!rst) begin
      if (host_req && (wait_cnt == WAIT_LIMIT)) begin
        host_win = 1'b1;                // anti-starvation override beats the lock
      end else if (core_req && core_lock) begin
        core_win = 1'b1;
      end else if (host_req && core_req) begin
        if (last_winner == WIN_CORE) host_win = 1'b1;
        else                         core_win = 1'b1;
      end else if (host_req) begin
        host_win = 1'b1;
      end else if (core_req) begin
        core_win = 1'b1;
      end
    end
  end

  assign host_gnt = host_win;
  assign core_gnt = core_win;

  always_comb begin
    state_next = IDLE;
    if (host_win)      state_next = HOST;
    else if (core_win) state_next = CORE;
  end

  // Counts cycles the host has been kept waiting; a dropped request restarts it.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!host_req || host_win)      wait_cnt_next = '0;
    else if (wait_cnt != WAIT_LIMIT) wait_cnt_next = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      last_winner <= WIN_CORE;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      rd_valid    <= '0;
      rd_host     <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (host_win) begin
        cmd_we      <= host_we;
        cmd_addr    <= host_addr;
        cmd_wdata   <= host_wdata;
        last_winner <= WIN_HOST;
      end else if (core_win) begin
        cmd_we      <= 1'b0;
        cmd_addr    <= core_addr;
        last_winner <= WIN_CORE;
      end
      rd_valid <= {rd_valid[0], (host_win && !host_we) || core_win};
      rd_host  <= {rd_host[0], host_win};
    end
  end

  // Pins decode from registered state, so reset returns them to idle immediately.
  always_comb begin
    ram_csb_n = (state == IDLE);
    ram_web_n = !((state != IDLE) && cmd_we);
    ram_oeb_n = !((state != IDLE) && !cmd_we);
  end

  assign ram_addr    = cmd_addr;
  assign ram_wdata   = cmd_wdata;
  assign host_rvalid = rd_valid[1] && rd_host[1];
  assign core_rvalid = rd_valid[1] && !rd_host[1];

endmodule

// File: tb/tb_point_ram_arbiter.sv
module tb_point_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req, host_we;
  logic [8:0]  host_addr;
  logic [49:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic        core_req, core_lock;
  logic [8:0]  core_addr;
  logic        core_gnt, core_rvalid;
  logic [8:0]  ram_addr;
  logic [49:0] ram_wdata;
  logic        ram_csb_n, ram_web_n, ram_oeb_n;

  logic [49:0] mem [512];
  logic [49:0] ram_rdata;

  typedef struct packed {
    logic        is_host;
    logic [49:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Expected core read data for addresses 0..7 (address 3 rewritten by the host).
  logic [49:0] core_exp [8] = '{50'h100, 50'h101, 50'h102, 50'h1A5,
                                50'h104, 50'h105, 50'h106, 50'h107};

  always #5 clk = ~clk;

  point_ram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .core_req    (core_req),
    .core_lock   (core_lock),
    .core_addr   (core_addr),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_csb_n   (ram_csb_n),
    .ram_web_n   (ram_web_n),
    .ram_oeb_n   (ram_oeb_n)
  );

  // Single-port RAM model: read data appears the cycle after the command.
  always @(posedge clk) begin
    if (!ram_csb_n) begin
      if (!ram_web_n)      mem[ram_addr] <= ram_wdata;
      else if (!ram_oeb_n) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every rvalid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (host_rvalid || core_rvalid)) begin
        if (host_rvalid && core_rvalid) check("both_rvalid", 64'd1, 64'd0);
        if (sb.size() == 0) begin
          check("spurious_rvalid", {62'd0, host_rvalid, core_rvalid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rvalid_owner", 64'(host_rvalid), 64'(e.is_host));
          check("rdata", 64'(ram_rdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    core_req = 0; core_lock = 0; core_addr = '0;
    for (int i = 0; i < 512; i++) mem[i] = 50'h100 + 50'(i);

    // Reset values, grants suppressed even with requests present.
    #2;
    host_req = 1; core_req = 1; core_lock = 1;
    #1;
    check("rst_csb", 64'(ram_csb_n), 64'd1);
    check("rst_web", 64'(ram_web_n), 64'd1);
    check("rst_oeb", 64'(ram_oeb_n), 64'd1);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    check("rst_rvalid", {62'd0, host_rvalid, core_rvalid}, 64'd0);
    check("rst_gnt", {62'd0, host_gnt, core_gnt}, 64'd0);
    host_req = 0; core_req = 0; core_lock = 0;
    step(); step();
    rst = 1'b0;
    step();

    // 1: host write 0x1A5 @3 then read it back.
    host_req = 1; host_we = 1; host_addr = 9'd3; host_wdata = 50'h1A5;
    #1;
    check("t1_wr_gnt", {62'd0, host_gnt, core_gnt}, 64'd2);
    step();
    check("t1_wr_pins", {61'd0, ram_csb_n, ram_web_n, ram_oeb_n}, 64'b001);
    check("t1_wr_addr", 64'(ram_addr), 64'd3);
    check("t1_wr_data", 64'(ram_wdata), 64'h1A5);
    host_we = 0;
    #1;
    check("t1_rd_gnt", 64'(host_gnt), 64'd1);
    sb.push_back({1'b1, 50'h1A5});
    step();
    check("t1_rd_pins", {61'd0, ram_csb_n, ram_web_n, ram_oeb_n}, 64'b010);
    host_req = 0;
    step();
    check("t1_idle_pins", {61'd0, ram_csb_n, ram_web_n, ram_oeb_n}, 64'b111);
    check("t1_addr_hold", 64'(ram_addr), 64'd3);
    drain();

    // 2: locked core stream over addresses 0..7.
    core_lock = 1; core_req = 1;
    for (int i = 0; i < 8; i++) begin
      core_addr = 9'(i);
      #1;
      check("t2_core_gnt", 64'(core_gnt), 64'd1);
      sb.push_back({1'b0, core_exp[i]});
      step();
    end
    core_req = 0; core_lock = 0;
    drain();

    // 3: starvation override at cycle 15 of a locked core stream.
    core_lock = 1; core_req = 1; core_addr = 9'd8;
    host_req = 1; host_we = 0; host_addr = 9'd5;
    for (int c = 0; c < 16; c++) begin
      #1;
      check("t3_host_gnt", 64'(host_gnt), (c == 15) ? 64'd1 : 64'd0);
      check("t3_core_gnt", 64'(core_gnt), (c == 15) ? 64'd0 : 64'd1);
      if (c == 15) sb.push_back({1'b1, 50'h105});
      else         sb.push_back({1'b0, 50'h108});
      step();
    end
    host_req = 0;
    #1;
    check("t3_core_resume", 64'(core_gnt), 64'd1);
    check("t3_wait_clr", 64'(dut.wait_cnt), 64'd0);
    sb.push_back({1'b0, 50'h108});
    step();
    core_req = 0; core_lock = 0;
    drain();

    // 4: round-robin from reset, host first.
    rst = 1'b1;
    step();
    rst = 1'b0;
    host_req = 1; host_we = 0; host_addr = 9'd1;
    core_req = 1; core_addr = 9'd2;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("t4_alternate", {62'd0, host_gnt, core_gnt}, (c % 2 == 0) ? 64'd2 : 64'd1);
      if (c % 2 == 0) sb.push_back({1'b1, 50'h101});
      else            sb.push_back({1'b0, 50'h102});
      step();
    end
    host_req = 0; core_req = 0;
    drain();

    // 5: reset between core read command and its rvalid.
    core_lock = 1; core_req = 1; core_addr = 9'd4;
    #1;
    check("t5_gnt", 64'(core_gnt), 64'd1);
    step();
    core_req = 0; core_lock = 0;
    check("t5_cmd_pins", {61'd0, ram_csb_n, ram_web_n, ram_oeb_n}, 64'b010);
    #1 rst = 1'b1;
    #1;
    check("t5_async_csb", 64'(ram_csb_n), 64'd1);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t5_no_rvalid", 64'(core_rvalid), 64'd0);
      step();
    end

    // 6: one-cycle host pulse lost to a locked core.
    core_lock = 1; core_req = 1; core_addr = 9'd6;
    host_req = 1; host_we = 0; host_addr = 9'd7;
    #1;
    check("t6_gnt", {62'd0, host_gnt, core_gnt}, 64'd1);
    sb.push_back({1'b0, 50'h106});
    step();
    host_req = 0;
    check("t6_wait_one", 64'(dut.wait_cnt), 64'd1);
    #1;
    check("t6_core_gnt", 64'(core_gnt), 64'd1);
    sb.push_back({1'b0, 50'h106});
    step();
    check("t6_wait_zero", 64'(dut.wait_cnt), 64'd0);
    check("t6_core_addr", 64'(ram_addr), 64'd6);
    core_req = 0;
    step();
    check("t6_idle", 64'(ram_csb_n), 64'd1);

    // Lock held with no core request: host served normally.
    host_req = 1; host_addr = 9'd0;
    #1;
    check("t6_lock_host", 64'(host_gnt), 64'd1);
    sb.push_back({1'b1, 50'h100});
    step();
    host_req = 0; core_lock = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
